// File: rtl/exu_wb_arb.sv
// exu_wb_arb: per-channel result FIFOs merged onto one registered register-file writeback port.
// Define EXU_WB_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module exu_wb_arb #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned XLEN   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH*XLEN-1:0] ch_wb_data,
  input  logic [NUM_CH*5-1:0]    ch_wb_rd_addr,
  input  logic [NUM_CH-1:0]      ch_wb_rd_wr_en,
  input  logic [NUM_CH*XLEN-1:0] ch_instr_tag,
  input  logic [NUM_CH*32-1:0]   ch_instr,
  output logic [NUM_CH-1:0]      ch_full,
  output logic [NUM_CH-1:0]      ch_afull,
  output logic [NUM_CH-1:0]      ch_ovf_err,
  output logic [XLEN-1:0]        exu_wb_data,
  output logic [4:0]             exu_wb_rd_addr,
  output logic                   exu_wb_rd_wr_en,
  output logic [XLEN-1:0]        instr_tag_out,
  output logic [31:0]            instr_out
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(NUM_CH);

  logic [XLEN-1:0] data_mem  [NUM_CH][DEPTH];
  logic [4:0]      addr_mem  [NUM_CH][DEPTH];
  logic [XLEN-1:0] tag_mem   [NUM_CH][DEPTH];
  logic [31:0]     instr_mem [NUM_CH][DEPTH];

  logic [PW-1:0] rd_ptr [NUM_CH];
  logic [PW-1:0] wr_ptr [NUM_CH];
  logic [CW-1:0] count  [NUM_CH];

  logic [NUM_CH-1:0] nonempty;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] ovf_set;
  logic              grant_vld;
  logic [IW-1:0]     grant_idx;

`ifdef EXU_WB_ARB_RR_EN
  logic [IW-1:0] rr_ptr;
  int unsigned   cand;
`endif

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      nonempty[i] = (count[i] != '0);
      ch_full[i]  = (count[i] == CW'(DEPTH));
      ch_afull[i] = (count[i] >= CW'(DEPTH - 1));
      req[i]      = ch_wb_rd_wr_en[i] && (ch_wb_rd_addr[i*5 +: 5] != 5'd0);
    end
  end

  // rr_ptr holds the first channel to search, i.e. one past the last grant
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
`ifdef EXU_WB_ARB_RR_EN
    cand = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cand = (32'(rr_ptr) + k) % NUM_CH;
      if (!grant_vld && nonempty[IW'(cand)]) begin
        grant_vld = 1'b1;
        grant_idx = IW'(cand);
      end
    end
`else
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (!grant_vld && nonempty[IW'(k)]) begin
        grant_vld = 1'b1;
        grant_idx = IW'(k);
      end
    end
`endif
  end

  always_comb begin
    pop = '0;
    pop[grant_idx] = grant_vld;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      push[i]    = req[i] && (!ch_full[i] || pop[i]);
      ovf_set[i] = req[i] && ch_full[i] && !pop[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (push[i]) begin
        data_mem[i][wr_ptr[i]]  <= ch_wb_data[i*XLEN +: XLEN];
        addr_mem[i][wr_ptr[i]]  <= ch_wb_rd_addr[i*5 +: 5];
        tag_mem[i][wr_ptr[i]]   <= ch_instr_tag[i*XLEN +: XLEN];
        instr_mem[i][wr_ptr[i]] <= ch_instr[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      ch_ovf_err      <= '0;
      exu_wb_rd_wr_en <= 1'b0;
      exu_wb_data     <= '0;
      exu_wb_rd_addr  <= '0;
      instr_tag_out   <= '0;
      instr_out       <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (!push[i] && pop[i]) count[i] <= count[i] - 1'b1;
      end
      ch_ovf_err      <= ch_ovf_err | ovf_set;
      exu_wb_rd_wr_en <= grant_vld;
      if (grant_vld) begin
        exu_wb_data    <= data_mem[grant_idx][rd_ptr[grant_idx]];
        exu_wb_rd_addr <= addr_mem[grant_idx][rd_ptr[grant_idx]];
        instr_tag_out  <= tag_mem[grant_idx][rd_ptr[grant_idx]];
        instr_out      <= instr_mem[grant_idx][rd_ptr[grant_idx]];
      end else begin
        exu_wb_data    <= '0;
        exu_wb_rd_addr <= '0;
        instr_tag_out  <= '0;
        instr_out      <= '0;
      end
    end
  end

`ifdef EXU_WB_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (grant_vld)
      rr_ptr <= (grant_idx == IW'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
  end
`endif

endmodule
